ripple_carry_adder: RTL and testbench
=====================================

Name: ripple_carry_adder

Overview:
- WIDTH-bit ripple-carry adder built from a chain of 1-bit full-adder cells. Computes x + y + c0 and produces sum and carry-out.
- The combinational result is available within the same evaluation, with no clock dependency.
- A registered copy of the result, plus a signed-overflow flag, is also provided for pipelined consumers in the datapath.

Parameters:
- WIDTH, 4, operand and sum width in bits; must be >= 1.

Ports:
- clk  input  1  rising-edge clock for the registered outputs.
- rst_n  input  1  asynchronous, active-low reset for the registered outputs.
- x  input  WIDTH  addend A, unsigned.
- y  input  WIDTH  addend B, unsigned.
- c0  input  1  carry-in to bit 0.
- s  output  WIDTH  combinational sum bits.
- cout  output  1  combinational carry-out of the MSB cell.
- s_q  output  WIDTH  s registered on clk.
- cout_q  output  1  cout registered on clk.
- ovf_q  output  1  registered two's-complement overflow flag.

Behaviour:
- Structure: WIDTH full-adder cells.
  - Cell i: s[i] = x[i] ^ y[i] ^ c[i]; c[i+1] = (x[i]&y[i]) | (x[i]&c[i]) | (y[i]&c[i]).
  - c[0] = c0 and cout = c[WIDTH].
  - Carry must ripple cell-to-cell; no lookahead logic.
- Arithmetic: {cout, s} = x + y + c0, computed exactly at WIDTH+1 bits. Maximum value is 2^(WIDTH+1)-1 (31 for WIDTH=4).
- s and cout are purely combinational:
  - Zero-cycle latency.
  - Settle after any change of x, y or c0, independent of clk and rst_n.
  - Never X when the inputs are known.
  - No latches.
- Signed overflow: ovf = c[WIDTH] ^ c[WIDTH-1]. For WIDTH=1, c[0]=c0 is used.
- Registered outputs, updated on each rising clk edge when rst_n=1:
  - s_q <= s, cout_q <= cout, ovf_q <= ovf.
  - Latency is 1 cycle from input sample to registered output.
- Reset:
  - rst_n=0 immediately and asynchronously forces s_q=0, cout_q=0, ovf_q=0, regardless of clk.
  - Registers hold 0 while rst_n is low.
  - The first capture is on the first rising edge after rst_n deasserts.
  - Reset asserted mid-operation clears the registered outputs at once. Combinational s and cout are unaffected by reset.
- Wrap-around: s is modulo 2^WIDTH, and the excess appears on cout. Examples for WIDTH=4:
  - 15+15+1 gives s=4'hF, cout=1.
  - 15+0+1 gives s=4'h0, cout=1.
  - 0+0+0 gives s=0, cout=0.
- No handshake and no state machine. Inputs are sampled unconditionally every cycle.

Test Plan:
- Exhaustive sweep for WIDTH=4: all 512 combinations of x (0..15), y (0..15), c0 (0..1). After each input change, wait a settle delay and check {cout,s} == x+y+c0. Required: 0 mismatches; the bench prints a pass banner when the error count is 0, otherwise the error count.
- Boundary vectors:
  - x=4'hF, y=4'hF, c0=1 -> s=4'hF, cout=1.
  - x=4'hF, y=4'h0, c0=1 -> s=4'h0, cout=1 (full ripple through all cells).
  - x=0, y=0, c0=0 -> s=0, cout=0.
- Overflow flag:
  - x=4'h7, y=4'h1, c0=0 -> s=4'h8, cout=0, ovf_q=1 after one clk edge.
  - x=4'h8, y=4'h8, c0=0 -> s=0, cout=1, ovf_q=1.
  - x=4'h3, y=4'h2, c0=0 -> ovf_q=0.
- Registered latency: apply x=4'h5, y=4'h6, c0=1 before edge N -> s=4'hC and cout=0 immediately; s_q=4'hC and cout_q=0 after edge N, not before.
- Asynchronous reset: with s_q nonzero, drive rst_n=0 between clock edges -> s_q, cout_q, ovf_q go to 0 without a clk edge, while s and cout still track the inputs. Release rst_n -> capture resumes on the next rising edge.
- Parameter check: WIDTH=8, x=8'hFF, y=8'h01, c0=0 -> s=8'h00, cout=1. Also sweep 1000 random vectors against x+y+c0.

Source files
------------

// File: rtl/ripple_carry_adder.sv
// ---------------------------------------------------------------------------
// ripple_carry_adder
//
// WIDTH-bit adder built as a chain of 1-bit full-adder cells. The carry
// ripples cell-to-cell with no lookahead, so the critical path is the full
// carry chain from c0 (or bit 0 of x/y) to cout.
//
// Combinational outputs (zero latency, independent of clk/rst_n):
//   s      [WIDTH-1:0]  sum bits, x + y + c0 modulo 2^WIDTH
//   cout                carry out of the MSB cell
//
// Registered outputs (one cycle after the inputs are sampled):
//   s_q    [WIDTH-1:0]  s captured on the rising edge of clk
//   cout_q              cout captured on the rising edge of clk
//   ovf_q               two's-complement overflow of the same addition
//
// Inputs:
//   clk     rising-edge clock for the registered outputs
//   rst_n   asynchronous active-low reset, clears the registered outputs only
//   x, y    [WIDTH-1:0] unsigned addends
//   c0      carry into bit 0
//
// There is no handshake: the inputs are sampled unconditionally every cycle.
// ---------------------------------------------------------------------------

// One full-adder cell. Kept as its own module so the carry chain stays an
// explicit cascade of cells rather than a '+' that synthesis could remap
// into a lookahead structure.
module rca_full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (a & ci) | (b & ci);

endmodule

module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c0,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic [WIDTH-1:0] s_q,
  output logic             cout_q,
  output logic             ovf_q
);

  // c[i] is the carry into cell i; c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0] c;
  logic           ovf;

  assign c[0] = c0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    rca_full_adder_cell u_cell (
      .a   (x[i]),
      .b   (y[i]),
      .ci  (c[i]),
      .sum (s[i]),
      .co  (c[i+1])
    );
  end

  assign cout = c[WIDTH];

  // Signed overflow happens when the carry into the sign cell differs from
  // the carry out of it. For WIDTH=1 the carry into the sign cell is c0,
  // which c[WIDTH-1] = c[0] already provides.
  assign ovf = c[WIDTH] ^ c[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      s_q    <= s;
      cout_q <= cout;
      ovf_q  <= ovf;
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// ---------------------------------------------------------------------------
// tb_ripple_carry_adder
//
// Directed bench for ripple_carry_adder. A WIDTH=4 instance covers reset,
// boundary vectors, overflow, registered latency, asynchronous reset and an
// exhaustive combinational sweep; a WIDTH=8 instance covers the wider
// parameter with a boundary vector and random vectors.
// ---------------------------------------------------------------------------
module tb_ripple_carry_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- WIDTH=4 DUT ----------------
  logic [3:0] x4, y4;
  logic       c04;
  logic [3:0] s4, s_q4;
  logic       cout4, cout_q4, ovf_q4;

  ripple_carry_adder #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .x      (x4),
    .y      (y4),
    .c0     (c04),
    .s      (s4),
    .cout   (cout4),
    .s_q    (s_q4),
    .cout_q (cout_q4),
    .ovf_q  (ovf_q4)
  );

  // ---------------- WIDTH=8 DUT ----------------
  logic [7:0] x8, y8;
  logic       c08;
  logic [7:0] s8, s_q8;
  logic       cout8, cout_q8, ovf_q8;

  ripple_carry_adder #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .x      (x8),
    .y      (y8),
    .c0     (c08),
    .s      (s8),
    .cout   (cout8),
    .s_q    (s_q8),
    .cout_q (cout_q8),
    .ovf_q  (ovf_q8)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    x4  = a;
    y4  = b;
    c04 = ci;
  endtask

  // Bench-side signed overflow model: sign-extend, add, test the range.
  function automatic logic ovf_model4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    int sa, sb, r;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    r  = sa + sb + int'(ci);
    return (r > 7) || (r < -8);
  endfunction

  // ---------------- directed steps ----------------
  initial begin
    logic [8:0] exp9;
    logic [3:0] ra, rb;
    logic       rc;

    drive4(4'h5, 4'h6, 1'b1);
    x8 = 8'h00; y8 = 8'h00; c08 = 1'b0;

    // Reset state, before and after a clock edge while rst_n is low.
    #1;
    check("rst_s_q",    9'(s_q4),    9'h0);
    check("rst_cout_q", 9'(cout_q4), 9'h0);
    check("rst_ovf_q",  9'(ovf_q4),  9'h0);
    check("rst_comb_s", {4'h0, cout4, s4}, 9'h0C);
    @(posedge clk); #1;
    check("rst_hold_s_q", 9'(s_q4), 9'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Boundary vectors, combinational.
    drive4(4'hF, 4'hF, 1'b1); #1;
    check("ff1_sum", {4'h0, cout4, s4}, 9'h1F);
    drive4(4'hF, 4'h0, 1'b1); #1;
    check("f01_sum", {4'h0, cout4, s4}, 9'h10);
    drive4(4'h0, 4'h0, 1'b0); #1;
    check("zero_sum", {4'h0, cout4, s4}, 9'h00);

    // Overflow: 7+1 (positive overflow, no carry out).
    @(negedge clk);
    drive4(4'h7, 4'h1, 1'b0); #1;
    check("ovf71_comb", {4'h0, cout4, s4}, 9'h08);
    @(posedge clk); #1;
    check("ovf71_ovf_q",  9'(ovf_q4),  9'h1);
    check("ovf71_s_q",    9'(s_q4),    9'h8);
    check("ovf71_cout_q", 9'(cout_q4), 9'h0);

    // Overflow: -8 + -8 (negative overflow with carry out).
    @(negedge clk);
    drive4(4'h8, 4'h8, 1'b0); #1;
    check("ovf88_comb", {4'h0, cout4, s4}, 9'h10);
    @(posedge clk); #1;
    check("ovf88_ovf_q",  9'(ovf_q4),  9'h1);
    check("ovf88_cout_q", 9'(cout_q4), 9'h1);
    check("ovf88_s_q",    9'(s_q4),    9'h0);

    // No overflow: 3+2.
    @(negedge clk);
    drive4(4'h3, 4'h2, 1'b0);
    @(posedge clk); #1;
    check("ovf32_ovf_q", 9'(ovf_q4), 9'h0);
    check("ovf32_s_q",   9'(s_q4),   9'h5);

    // Registered latency: 5+6+1 visible combinationally at once, on s_q
    // only after the next edge.
    @(negedge clk);
    drive4(4'h5, 4'h6, 1'b1); #1;
    check("lat_comb",       {4'h0, cout4, s4}, 9'h0C);
    check("lat_s_q_before", 9'(s_q4), 9'h5);
    @(posedge clk); #1;
    check("lat_s_q_after",  9'(s_q4),    9'hC);
    check("lat_cout_q",     9'(cout_q4), 9'h0);
    check("lat_ovf_q",      9'(ovf_q4),  9'h1);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_s_q",    9'(s_q4),    9'h0);
    check("arst_cout_q", 9'(cout_q4), 9'h0);
    check("arst_ovf_q",  9'(ovf_q4),  9'h0);
    check("arst_comb",   {4'h0, cout4, s4}, 9'h0C);
    drive4(4'h1, 4'h2, 1'b0); #1;
    check("arst_comb_track", {4'h0, cout4, s4}, 9'h03);
    @(posedge clk); #1;
    check("arst_hold_s_q", 9'(s_q4), 9'h0);
    @(negedge clk);
    rst_n = 1'b1; #1;
    check("arst_rel_s_q", 9'(s_q4), 9'h0);
    @(posedge clk); #1;
    check("arst_resume_s_q", 9'(s_q4), 9'h3);

    // Exhaustive combinational sweep of the WIDTH=4 instance.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int ci = 0; ci < 2; ci++) begin
          drive4(4'(a), 4'(b), 1'(ci));
          #1;
          exp9 = 9'(a + b + ci);
          check("sweep4", {4'h0, cout4, s4}, exp9);
        end
      end
    end

    // Random registered vectors, overflow checked against a signed model.
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      drive4(ra, rb, rc);
      @(posedge clk); #1;
      exp9 = 9'(int'(ra) + int'(rb) + int'(rc));
      check("rand4_reg_sum", {4'h0, cout_q4, s_q4}, exp9);
      check("rand4_ovf_q",   9'(ovf_q4), 9'(ovf_model4(ra, rb, rc)));
    end

    // WIDTH=8: boundary vector and random vectors.
    x8 = 8'hFF; y8 = 8'h01; c08 = 1'b0; #1;
    check("w8_ff01", {cout8, s8}, 9'h100);
    x8 = 8'hFF; y8 = 8'hFF; c08 = 1'b1; #1;
    check("w8_ffff1", {cout8, s8}, 9'h1FF);
    for (int k = 0; k < 1000; k++) begin
      x8  = 8'($urandom_range(0, 255));
      y8  = 8'($urandom_range(0, 255));
      c08 = 1'($urandom_range(0, 1));
      #1;
      exp9 = 9'(int'(x8) + int'(y8) + int'(c08));
      check("rand8", {cout8, s8}, exp9);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
